// File: rtl/hazard_scoreboard_if.sv
// Decode/execute hazard bundle between pipeline control and the scoreboard.
// Latency: none, pure signal grouping.
// Backpressure: stall/flush outputs are the backpressure toward F/D/E.
interface hazard_scoreboard_if #(
    parameter int NREG = 16,
    parameter int RAW  = 4,
    parameter int NSRC = 3
);
    logic                issue_valid;
    logic                issue_wr;
    logic                issue_load;
    logic                issue_pcwr;
    logic [RAW-1:0]      issue_dst;
    logic [NSRC*RAW-1:0] src_addr;
    logic [NSRC-1:0]     src_used;
    logic                branch_taken_e;
    logic [RAW-1:0]      rd_e;
    logic [RAW-1:0]      rd_m;
    logic [RAW-1:0]      rd_w;
    logic                regwrite_m;
    logic                regwrite_w;
    logic [2*RAW-1:0]    src_e;
    logic                stall_f;
    logic                stall_d;
    logic                flush_d;
    logic                flush_e;
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;
    logic [NREG-1:0]     busy;
    logic [15:0]         stall_cnt;

    // Pipeline side: drives decode/execute state, receives control.
    modport master (
        output issue_valid, issue_wr, issue_load, issue_pcwr, issue_dst,
        output src_addr, src_used, branch_taken_e, rd_e, rd_m, rd_w,
        output regwrite_m, regwrite_w, src_e,
        input  stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, busy, stall_cnt
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_wr, issue_load, issue_pcwr, issue_dst,
        input  src_addr, src_used, branch_taken_e, rd_e, rd_m, rd_w,
        input  regwrite_m, regwrite_w, src_e,
        output stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, busy, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use / PC-write hazard scoreboard with E-stage forwarding selects.
// Latency: stall/flush/fwd combinational from inputs; busy and stall_cnt from registers.
// Backpressure: holds F/D while a load result or PC write is pending; branch flush wins over stall.
module hazard_scoreboard #(
    parameter int NREG   = 16,
    parameter int RAW    = 4,
    parameter int NSRC   = 3,
    parameter int LD_LAT = 2,
    parameter int PC_LAT = 3,
    parameter int PC_REG = 15
) (
    input  logic clk,
    input  logic reset,
    hazard_scoreboard_if.slave hz
);
    localparam int CNTW = 3;
    localparam logic [CNTW-1:0] LD_LAT_C = CNTW'(LD_LAT);
    localparam logic [CNTW-1:0] PC_LAT_C = CNTW'(PC_LAT);
    localparam logic [RAW-1:0]  PC_REG_C = RAW'(PC_REG);

    logic [CNTW-1:0] cnt [NREG];
    logic [CNTW-1:0] pc_cnt;
    logic [15:0]     stall_cnt_q;
    logic [NREG-1:0] busy_w;
    logic            ld_stall;
    logic            pc_pend;
    logic            accept;
    logic            ld_alloc;
    logic            pc_alloc;
    logic [RAW-1:0]  src_k;
    logic            unused_rd_e;

    // rd_e is not needed: in-flight loads are tracked by the busy counters.
    assign unused_rd_e = ^hz.rd_e;

    // A register is busy while its load-use counter is still running.
    always_comb begin
        busy_w = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_w[r] = (cnt[r] != '0);
        end
    end

    // Load-use hazard: any used source that is busy; PC reads are never hazards.
    always_comb begin
        ld_stall = 1'b0;
        src_k    = '0;
        for (int k = 0; k < NSRC; k++) begin
            src_k = hz.src_addr[k*RAW +: RAW];
            if (hz.src_used[k] && (src_k != PC_REG_C) && busy_w[src_k]) begin
                ld_stall = 1'b1;
            end
        end
    end

    assign pc_pend  = (pc_cnt != '0);
    assign accept   = hz.issue_valid & ~ld_stall & ~pc_pend & ~hz.branch_taken_e;
    assign ld_alloc = accept & hz.issue_load & hz.issue_wr;
    assign pc_alloc = accept & (hz.issue_pcwr | (hz.issue_wr & (hz.issue_dst == PC_REG_C)));

    // Per-register load counters: reload on an accepted load, otherwise drain to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                logic [CNTW-1:0] dec;
                dec = (cnt[r] != '0) ? cnt[r] - 1'b1 : '0;
                if (ld_alloc && (hz.issue_dst == RAW'(r))) begin
                    cnt[r] <= (dec > LD_LAT_C) ? dec : LD_LAT_C;
                end else begin
                    cnt[r] <= dec;
                end
            end
        end
    end

    // PC-write window: armed by an accepted PC write, killed by a taken branch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_cnt <= '0;
        end else if (pc_alloc) begin
            pc_cnt <= PC_LAT_C;
        end else if (hz.branch_taken_e) begin
            pc_cnt <= '0;
        end else if (pc_pend) begin
            pc_cnt <= pc_cnt - 1'b1;
        end
    end

    // Saturating count of cycles a valid D instruction spent load-use stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (ld_stall && hz.issue_valid && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    // Forwarding select per E operand: M beats W, PC is never forwarded.
    always_comb begin
        logic [RAW-1:0] sa;
        logic [RAW-1:0] sb;
        sa = hz.src_e[RAW-1:0];
        sb = hz.src_e[2*RAW-1:RAW];
        hz.fwd_a = 2'b00;
        hz.fwd_b = 2'b00;
        if (sa != PC_REG_C) begin
            if (hz.regwrite_m && (hz.rd_m == sa))      hz.fwd_a = 2'b10;
            else if (hz.regwrite_w && (hz.rd_w == sa)) hz.fwd_a = 2'b01;
        end
        if (sb != PC_REG_C) begin
            if (hz.regwrite_m && (hz.rd_m == sb))      hz.fwd_b = 2'b10;
            else if (hz.regwrite_w && (hz.rd_w == sb)) hz.fwd_b = 2'b01;
        end
    end

    // A taken branch turns a load-use stall into a flush of D.
    assign hz.stall_f   = ld_stall | pc_pend;
    assign hz.stall_d   = ld_stall & ~hz.branch_taken_e;
    assign hz.flush_d   = pc_pend | hz.branch_taken_e;
    assign hz.flush_e   = ld_stall | hz.branch_taken_e;
    assign hz.busy      = busy_w;
    assign hz.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, PC write, forwarding, reset, saturation.
// Latency: inputs applied on negedge, combinational outputs sampled 1ns later.
// Backpressure: checked through stall/flush outputs against hand-computed values.
module tb_hazard_scoreboard;
    logic clk;
    logic reset;
    int   passed;
    int   total;

    hazard_scoreboard_if #(.NREG(16), .RAW(4), .NSRC(3)) hz ();
    hazard_scoreboard_if #(.NREG(16), .RAW(4), .NSRC(3)) hz7 ();

    hazard_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    // Second instance with the longest load latency keeps the saturation run short.
    hazard_scoreboard #(.LD_LAT(7)) dut7 (
        .clk   (clk),
        .reset (reset),
        .hz    (hz7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        hz.issue_valid    = 1'b0;
        hz.issue_wr       = 1'b0;
        hz.issue_load     = 1'b0;
        hz.issue_pcwr     = 1'b0;
        hz.issue_dst      = '0;
        hz.src_addr       = '0;
        hz.src_used       = '0;
        hz.branch_taken_e = 1'b0;
        hz.rd_e           = '0;
        hz.rd_m           = '0;
        hz.rd_w           = '0;
        hz.regwrite_m     = 1'b0;
        hz.regwrite_w     = 1'b0;
        hz.src_e          = '0;
    endtask

    task automatic idle7();
        hz7.issue_valid    = 1'b0;
        hz7.issue_wr       = 1'b0;
        hz7.issue_load     = 1'b0;
        hz7.issue_pcwr     = 1'b0;
        hz7.issue_dst      = '0;
        hz7.src_addr       = '0;
        hz7.src_used       = '0;
        hz7.branch_taken_e = 1'b0;
        hz7.rd_e           = '0;
        hz7.rd_m           = '0;
        hz7.rd_w           = '0;
        hz7.regwrite_m     = 1'b0;
        hz7.regwrite_w     = 1'b0;
        hz7.src_e          = '0;
    endtask

    // One load R3 then seven load-use stall cycles on the LD_LAT=7 instance.
    task automatic sat_iter();
        idle7();
        hz7.issue_valid = 1'b1;
        hz7.issue_load  = 1'b1;
        hz7.issue_wr    = 1'b1;
        hz7.issue_dst   = 4'd3;
        @(negedge clk);
        idle7();
        hz7.issue_valid = 1'b1;
        hz7.src_addr    = {4'd0, 4'd0, 4'd3};
        hz7.src_used    = 3'b001;
        repeat (7) @(negedge clk);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b0;
        idle();
        idle7();

        // Reset state: flush_e follows branch, forwarding still live.
        hz.branch_taken_e = 1'b1;
        hz.regwrite_m     = 1'b1;
        hz.rd_m           = 4'd5;
        hz.src_e          = {4'd0, 4'd5};
        @(negedge clk); #1;
        chk("rst_busy", hz.busy, 16'h0000);
        chk("rst_stall_cnt", hz.stall_cnt, 16'h0000);
        chk("rst_stall_f", hz.stall_f, 0);
        chk("rst_stall_d", hz.stall_d, 0);
        chk("rst_flush_d", hz.flush_d, 1);
        chk("rst_flush_e", hz.flush_e, 1);
        chk("rst_fwd_a", hz.fwd_a, 2'b10);
        hz.branch_taken_e = 1'b0;
        #1;
        chk("rst_flush_d_nobr", hz.flush_d, 0);
        chk("rst_flush_e_nobr", hz.flush_e, 0);
        @(negedge clk);
        reset = 1'b1;
        idle();

        // Load-use: load R3, then consumer on port 0 stalls for LD_LAT=2 cycles.
        @(negedge clk);
        hz.issue_valid = 1'b1; hz.issue_load = 1'b1; hz.issue_wr = 1'b1; hz.issue_dst = 4'd3;
        #1 chk("lu_acc_stall_f", hz.stall_f, 0);
        @(negedge clk);
        idle();
        hz.issue_valid = 1'b1; hz.src_addr = {4'd0, 4'd0, 4'd3}; hz.src_used = 3'b001;
        #1;
        chk("lu_c1_busy", hz.busy, 16'h0008);
        chk("lu_c1_stall_f", hz.stall_f, 1);
        chk("lu_c1_stall_d", hz.stall_d, 1);
        chk("lu_c1_flush_e", hz.flush_e, 1);
        chk("lu_c1_flush_d", hz.flush_d, 0);
        @(negedge clk); #1;
        chk("lu_c2_stall_f", hz.stall_f, 1);
        chk("lu_c2_stall_cnt", hz.stall_cnt, 1);
        @(negedge clk); #1;
        chk("lu_c3_stall_f", hz.stall_f, 0);
        chk("lu_c3_stall_d", hz.stall_d, 0);
        chk("lu_c3_stall_cnt", hz.stall_cnt, 2);
        chk("lu_c3_busy", hz.busy, 16'h0000);

        // Load into PC_REG: PC window opens, PC reads never flag a load hazard.
        @(negedge clk);
        idle();
        hz.issue_valid = 1'b1; hz.issue_load = 1'b1; hz.issue_wr = 1'b1; hz.issue_dst = 4'd15;
        #1 chk("pcld_acc_stall_f", hz.stall_f, 0);
        @(negedge clk);
        idle();
        hz.issue_valid = 1'b1; hz.src_addr = {4'd0, 4'd15, 4'd0}; hz.src_used = 3'b010;
        #1;
        chk("pcld_busy", hz.busy, 16'h8000);
        chk("pcld_flush_e", hz.flush_e, 0);
        chk("pcld_stall_d", hz.stall_d, 0);
        chk("pcld_stall_f", hz.stall_f, 1);
        chk("pcld_flush_d", hz.flush_d, 1);
        @(negedge clk);
        idle();
        #1 chk("pcld_c2_stall_f", hz.stall_f, 1);
        @(negedge clk); #1;
        chk("pcld_c3_stall_f", hz.stall_f, 1);
        @(negedge clk); #1;
        chk("pcld_c4_stall_f", hz.stall_f, 0);
        chk("pcld_c4_flush_d", hz.flush_d, 0);
        chk("pcld_stall_cnt", hz.stall_cnt, 2);

        // PC write with a taken branch in the second blocked cycle.
        @(negedge clk);
        idle();
        hz.issue_valid = 1'b1; hz.issue_pcwr = 1'b1;
        #1 chk("pcw_acc_stall_f", hz.stall_f, 0);
        @(negedge clk);
        idle();
        hz.issue_valid = 1'b1;
        #1;
        chk("pcw_c1_stall_f", hz.stall_f, 1);
        chk("pcw_c1_flush_d", hz.flush_d, 1);
        @(negedge clk);
        hz.branch_taken_e = 1'b1;
        #1;
        chk("pcw_c2_stall_f", hz.stall_f, 1);
        chk("pcw_c2_flush_d", hz.flush_d, 1);
        chk("pcw_c2_flush_e", hz.flush_e, 1);
        @(negedge clk);
        idle();
        #1;
        chk("pcw_c3_stall_f", hz.stall_f, 0);
        chk("pcw_c3_flush_d", hz.flush_d, 0);

        // Forwarding priority and PC exclusion.
        @(negedge clk);
        hz.regwrite_m = 1'b1; hz.rd_m = 4'd5; hz.regwrite_w = 1'b1; hz.rd_w = 4'd5;
        hz.src_e = {4'd15, 4'd5};
        #1;
        chk("fwd_prio_a", hz.fwd_a, 2'b10);
        chk("fwd_prio_b", hz.fwd_b, 2'b00);
        @(negedge clk);
        hz.rd_m = 4'd2; hz.rd_w = 4'd5; hz.src_e = {4'd2, 4'd5};
        #1;
        chk("fwd_w_a", hz.fwd_a, 2'b01);
        chk("fwd_m_b", hz.fwd_b, 2'b10);
        @(negedge clk);
        hz.regwrite_m = 1'b0;
        #1 chk("fwd_m_off_b", hz.fwd_b, 2'b00);
        @(negedge clk);
        hz.regwrite_m = 1'b1; hz.rd_m = 4'd15; hz.rd_w = 4'd15; hz.src_e = {4'd15, 4'd15};
        #1 chk("fwd_pc_a", hz.fwd_a, 2'b00);
        @(negedge clk);
        idle();

        // Load-use coinciding with a taken branch: flush, no stall, no allocation.
        @(negedge clk);
        hz.issue_valid = 1'b1; hz.issue_load = 1'b1; hz.issue_wr = 1'b1; hz.issue_dst = 4'd4;
        @(negedge clk);
        idle();
        hz.issue_valid = 1'b1; hz.issue_load = 1'b1; hz.issue_wr = 1'b1; hz.issue_dst = 4'd6;
        hz.src_addr = {4'd4, 4'd0, 4'd0}; hz.src_used = 3'b100; hz.branch_taken_e = 1'b1;
        #1;
        chk("brst_stall_d", hz.stall_d, 0);
        chk("brst_flush_d", hz.flush_d, 1);
        chk("brst_flush_e", hz.flush_e, 1);
        chk("brst_busy", hz.busy, 16'h0010);
        @(negedge clk);
        idle();
        #1;
        chk("brst_noalloc_busy", hz.busy, 16'h0010);
        chk("brst_stall_cnt", hz.stall_cnt, 3);
        @(negedge clk); #1;
        chk("brst_drain_busy", hz.busy, 16'h0000);

        // Load whose dst is its own busy source waits for the stall, then allocates.
        @(negedge clk);
        hz.issue_valid = 1'b1; hz.issue_load = 1'b1; hz.issue_wr = 1'b1; hz.issue_dst = 4'd3;
        @(negedge clk);
        hz.src_addr = {4'd0, 4'd0, 4'd3}; hz.src_used = 3'b001;
        #1 chk("self_c1_stall_d", hz.stall_d, 1);
        @(negedge clk); #1;
        chk("self_c2_stall_d", hz.stall_d, 1);
        @(negedge clk); #1;
        chk("self_c3_stall_d", hz.stall_d, 0);
        chk("self_stall_cnt", hz.stall_cnt, 5);
        @(negedge clk);
        idle();
        #1 chk("self_realloc_busy", hz.busy, 16'h0008);
        repeat (2) @(negedge clk);

        // Reset in the middle of a load-use stall.
        hz.issue_valid = 1'b1; hz.issue_load = 1'b1; hz.issue_wr = 1'b1; hz.issue_dst = 4'd3;
        @(negedge clk);
        idle();
        hz.issue_valid = 1'b1; hz.src_addr = {4'd0, 4'd0, 4'd3}; hz.src_used = 3'b001;
        #1;
        chk("rstmid_pre_stall_f", hz.stall_f, 1);
        chk("rstmid_pre_busy", hz.busy, 16'h0008);
        #1 reset = 1'b0;
        #1;
        chk("rstmid_busy", hz.busy, 16'h0000);
        chk("rstmid_stall_cnt", hz.stall_cnt, 16'h0000);
        chk("rstmid_stall_f", hz.stall_f, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstmid_post_stall_f", hz.stall_f, 0);
        chk("rstmid_post_stall_d", hz.stall_d, 0);
        @(negedge clk);
        idle();
        #1 chk("rstmid_post_stall_cnt", hz.stall_cnt, 0);

        // Saturation: 7 stall cycles per iteration on the LD_LAT=7 instance.
        sat_iter();
        #1 chk("sat_first_iter", hz7.stall_cnt, 7);
        for (int i = 0; i < 9362; i++) begin
            sat_iter();
        end
        #1 chk("sat_hold", hz7.stall_cnt, 16'hFFFF);
        sat_iter();
        #1 chk("sat_hold_again", hz7.stall_cnt, 16'hFFFF);
        idle7();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
